instr_fetch_unit: RTL and testbench

//   Instruction fetch front end; producer side of the instruction interface consumed by the

---
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, single-outstanding imem requests, instruction FIFO and redirect flush.
// Optional feature macro IFU_BYPASS_EN: an acked word is presented in the same cycle when the buffer is empty.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam int unsigned       PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [ADDR_W-1:0]  fetch_pc_r;
    logic [ADDR_W-1:0]  fetch_pc_next_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  addr_next_s;
    logic               req_r;
    logic [31:0]        instr_mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pc_mem_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               ack_s;
    logic               resp_s;
    logic               fifo_valid_s;
    logic               bypass_s;
    logic               bypass_take_s;
    logic               pop_s;
    logic               push_s;
    logic               credit_s;
    logic [ADDR_W-1:0]  redirect_target_s;
    logic               unused_s;

    assign unused_s = ^redirect_pc_i[1:0];

    // Qualify the memory response and decide push/pop for this cycle
    always_comb begin
        ack_s             = imem_ack_i & req_r;
        resp_s            = ack_s & (state_r == ST_REQ);
        fifo_valid_s      = (count_r != {CNT_W{1'b0}});
`ifdef IFU_BYPASS_EN
        bypass_s          = ~fifo_valid_s & resp_s & ~redirect_i;
`else
        bypass_s          = 1'b0;
`endif
        bypass_take_s     = bypass_s & instr_ready_i;
        pop_s             = fifo_valid_s & instr_ready_i & ~redirect_i;
        push_s            = resp_s & ~redirect_i & ~bypass_take_s;
        redirect_target_s = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    end

    // Present the FIFO head (or the bypassed response) to decode
    always_comb begin
        instr_valid_o = fifo_valid_s | bypass_s;
        if (fifo_valid_s) begin
            instr_o    = instr_mem_r[rd_ptr_r];
            instr_pc_o = pc_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            instr_o    = imem_data_i;
            instr_pc_o = fetch_pc_r;
        end else begin
            instr_o    = 32'h0000_0000;
            instr_pc_o = {ADDR_W{1'b0}};
        end
    end

    // Occupancy after this cycle and whether another request may be issued
    always_comb begin
        count_next_s = count_r;
        if (redirect_i) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1'b1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1'b1);
        end else begin
            count_next_s = count_r;
        end
        credit_s = (count_next_s < DEPTH_C);
    end

    // Fetch FSM next state and fetch PC
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        if (redirect_i) begin
            // An un-acked request must still be drained before the new PC is fetched
            fetch_pc_next_s = redirect_target_s;
            state_next_s    = (req_r && !ack_s) ? ST_FLUSH : ST_REQ;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = credit_s ? ST_REQ : ST_IDLE;
                end
                ST_REQ: begin
                    if (ack_s) begin
                        fetch_pc_next_s = fetch_pc_r + PC_STEP;
                        state_next_s    = credit_s ? ST_REQ : ST_IDLE;
                    end else begin
                        state_next_s    = ST_REQ;
                    end
                end
                ST_FLUSH: begin
                    if (ack_s) begin
                        state_next_s = credit_s ? ST_REQ : ST_IDLE;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
        addr_next_s = (state_next_s == ST_FLUSH) ? addr_r : fetch_pc_next_s;
    end

    assign imem_req_o  = req_r;
    assign imem_addr_o = addr_r;

    // FSM, PC, request outputs and FIFO pointers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            addr_r     <= addr_next_s;
            req_r      <= (state_next_s != ST_IDLE);
            count_r    <= count_next_s;
            if (redirect_i) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
                end
            end
        end
    end

    // Instruction buffer storage; contents are only visible through the count
    always_ff @(posedge clk_i) begin
        if (rst_i && push_s) begin
            instr_mem_r[wr_ptr_r] <= imem_data_i;
            pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: random-latency memory, random ready/redirect, PC-stream reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        req, ack, valid, ready, redirect;
    logic [31:0] addr, data, instr, ipc, redirect_pc;
    logic        w_req, w_ack, w_valid, w_ready, w_redirect;
    logic [31:0] w_addr, w_data, w_instr, w_ipc, w_redirect_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
        .imem_data_i(data), .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc),
        .instr_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
        .clk_i(clk), .rst_i(rst), .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_ack),
        .imem_data_i(w_data), .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_ipc),
        .instr_ready_i(w_ready), .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc)
    );

    int          checks;
    int          errors;
    logic [31:0] exp_pc;
    int          accepted;
    int          ack_cnt;
    bit          mem_auto;
    int          mem_max_lat;
    int          mem_wait;
    int          mem_lat;
    bit          wrap_collect;
    logic [31:0] wrap_pcs[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: drive memory responses at the negedge, run the reference model, wait for next negedge
    task automatic tick();
        if (mem_auto) begin
            if (!req || ack) begin
                mem_wait = 0;
                mem_lat  = $urandom_range(mem_max_lat, 0);
            end
            if (req && mem_wait >= mem_lat) begin
                ack  = 1'b1;
                data = word_of(addr);
            end else begin
                ack  = 1'b0;
                data = $urandom;
                if (req) mem_wait++;
            end
        end
        w_ack  = w_req;
        w_data = word_of(w_addr);
        #1;
        if (ack && req && rst) ack_cnt++;
        if (!rst) begin
            exp_pc = 32'h0000_0000;
        end else if (redirect) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (valid && ready) begin
            checks++;
            if (ipc !== exp_pc || instr !== word_of(exp_pc)) begin
                errors++;
                $display("FAIL stream: got pc %h instr %h, expected pc %h instr %h",
                         ipc, instr, exp_pc, word_of(exp_pc));
            end
            exp_pc   = exp_pc + 32'd4;
            accepted++;
        end
        if (wrap_collect && rst && w_valid) begin
            checks++;
            if (w_instr !== word_of(w_ipc)) begin
                errors++;
                $display("FAIL wrap_data: got %h for pc %h, expected %h", w_instr, w_ipc, word_of(w_ipc));
            end
            wrap_pcs.push_back(w_ipc);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        redirect = 1'b0;
        ack      = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        ready    = 1'b0;
        mem_auto = 1'b1;
        apply_reset();
        checks++;
        if (req !== 1'b0 || addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_req: got req %b addr %h, expected 0 / 00000000", req, addr);
        end
        checks++;
        if (valid !== 1'b0 || instr !== 32'h0 || ipc !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got valid %b instr %h pc %h, expected all zero", valid, instr, ipc);
        end
        checks++;
        if (w_req !== 1'b0 || w_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL reset_wrap_addr: got req %b addr %h, expected 0 / fffffff8", w_req, w_addr);
        end
    endtask

    task automatic test_stream();
        bit seen;
        apply_reset();
        mem_auto    = 1'b1;
        mem_max_lat = 0;
        ready       = 1'b1;
        accepted    = 0;
        seen        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) seen = 1'b1;
            else if (seen) begin
                checks++;
                errors++;
                $display("FAIL stream_gap: got valid 0 at cycle %0d, expected 1", i);
            end
        end
        checks++;
        if (accepted != 18) begin
            errors++;
            $display("FAIL stream_rate: got %0d instructions, expected 18", accepted);
        end
    endtask

    task automatic test_backpressure();
        bit          held;
        logic [31:0] h_instr, h_pc;
        apply_reset();
        mem_auto    = 1'b1;
        mem_max_lat = 0;
        ready       = 1'b0;
        ack_cnt     = 0;
        held        = 1'b0;
        h_instr     = 32'h0;
        h_pc        = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) begin
                if (!held) begin
                    held    = 1'b1;
                    h_instr = instr;
                    h_pc    = ipc;
                end else begin
                    checks++;
                    if (instr !== h_instr || ipc !== h_pc) begin
                        errors++;
                        $display("FAIL bp_stable: got %h/%h, expected %h/%h", instr, ipc, h_instr, h_pc);
                    end
                end
            end
        end
        checks++;
        if (ack_cnt != DEPTH || req !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill: got %0d words req %b, expected %0d words req 0", ack_cnt, req, DEPTH);
        end
        checks++;
        if (valid !== 1'b1 || ipc !== 32'h0 || instr !== word_of(32'h0)) begin
            errors++;
            $display("FAIL bp_head: got valid %b pc %h instr %h, expected 1 / 0 / %h",
                     valid, ipc, instr, word_of(32'h0));
        end
        ready       = 1'b1;
        mem_max_lat = 2;
        accepted    = 0;
        repeat (12) tick();
        checks++;
        if (accepted < 4) begin
            errors++;
            $display("FAIL bp_drain: got %0d instructions, expected at least 4", accepted);
        end
    endtask

    task automatic test_redirect_flush();
        apply_reset();
        mem_auto = 1'b0;
        ack      = 1'b0;
        ready    = 1'b1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        checks++;
        if (req !== 1'b1 || addr !== 32'h0000_0000 || valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: got req %b addr %h valid %b, expected 1 / 00000000 / 0", req, addr, valid);
        end
        tick();
        tick();
        ack  = 1'b1;
        data = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        checks++;
        if (req !== 1'b1 || addr !== 32'h0000_0100 || valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_newreq: got req %b addr %h valid %b, expected 1 / 00000100 / 0", req, addr, valid);
        end
        ack  = 1'b1;
        data = word_of(32'h0000_0100);
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b1 || ipc !== 32'h0000_0100 || instr !== word_of(32'h0000_0100)) begin
            errors++;
            $display("FAIL flush_first: got valid %b pc %h instr %h, expected 1 / 00000100 / %h",
                     valid, ipc, instr, word_of(32'h0000_0100));
        end
        tick();
        mem_auto = 1'b1;
    endtask

    task automatic test_redirect_ack_pop();
        apply_reset();
        mem_auto    = 1'b1;
        mem_max_lat = 0;
        ready       = 1'b1;
        repeat (6) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL rd_ack_pop: got valid %b req %b addr %h, expected 0 / 1 / 00000200", valid, req, addr);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || ipc !== 32'h0000_0200) begin
            errors++;
            $display("FAIL rd_ack_first: got valid %b pc %h, expected 1 / 00000200", valid, ipc);
        end
        repeat (4) tick();
    endtask

    task automatic test_stray_ack();
        apply_reset();
        mem_auto = 1'b0;
        ack      = 1'b0;
        ready    = 1'b1;
        tick();
        ack  = 1'b1;
        data = word_of(32'h0);
        tick();
        ack = 1'b0;
        tick();
        rst  = 1'b0;
        ack  = 1'b1;
        data = 32'hDEAD_BEEF;
        tick();
        rst = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL stray_ack: got valid %b req %b addr %h, expected 0 / 1 / 00000000", valid, req, addr);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: got valid %b, expected 0", valid);
        end
        ack  = 1'b1;
        data = word_of(32'h0);
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b1 || ipc !== 32'h0 || instr !== word_of(32'h0)) begin
            errors++;
            $display("FAIL stray_first: got valid %b pc %h instr %h, expected 1 / 00000000 / %h",
                     valid, ipc, instr, word_of(32'h0));
        end
        tick();
        mem_auto = 1'b1;
    endtask

    task automatic test_wrap();
        apply_reset();
        wrap_pcs.delete();
        wrap_collect = 1'b1;
        repeat (8) tick();
        wrap_collect = 1'b0;
        checks++;
        if (wrap_pcs.size() < 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d instructions, expected at least 3", wrap_pcs.size());
        end else if (wrap_pcs[0] !== 32'hFFFF_FFF8 || wrap_pcs[1] !== 32'hFFFF_FFFC || wrap_pcs[2] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pcs: got %h %h %h, expected fffffff8 fffffffc 00000000",
                     wrap_pcs[0], wrap_pcs[1], wrap_pcs[2]);
        end
    endtask

    task automatic test_random();
        bit          hold;
        logic [31:0] h_instr, h_pc;
        apply_reset();
        mem_auto    = 1'b1;
        mem_max_lat = 3;
        accepted    = 0;
        hold        = 1'b0;
        h_instr     = 32'h0;
        h_pc        = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            ready       = ($urandom_range(3, 0) != 0);
            redirect    = ($urandom_range(31, 0) == 0);
            redirect_pc = $urandom & 32'h0000_FFFF;
            if (hold) begin
                checks++;
                if (valid !== 1'b1 || instr !== h_instr || ipc !== h_pc) begin
                    errors++;
                    $display("FAIL rand_stable: got %b %h/%h, expected 1 %h/%h", valid, instr, ipc, h_instr, h_pc);
                end
            end
            hold    = valid && !ready && !redirect;
            h_instr = instr;
            h_pc    = ipc;
            tick();
        end
        redirect = 1'b0;
        checks++;
        if (accepted < 300) begin
            errors++;
            $display("FAIL rand_progress: got %0d instructions, expected at least 300", accepted);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_pc        = 32'h0;
        accepted      = 0;
        ack_cnt       = 0;
        mem_auto      = 1'b1;
        mem_max_lat   = 0;
        mem_wait      = 0;
        mem_lat       = 0;
        wrap_collect  = 1'b0;
        rst           = 1'b0;
        ack           = 1'b0;
        data          = 32'h0;
        ready         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        w_ack         = 1'b0;
        w_data        = 32'h0;
        w_ready       = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_ack_pop();
        test_stray_ack();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
